// File: rtl/gpu_pkg.sv
// Shared miniGPU definitions: core_state encodings used by the scheduler,
// RegisterFile, ALUs, LSUs and the fetcher, plus default widths.
package gpu_pkg;

  localparam int DEFAULT_PC_BITS = 8;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = CORE_IDLE,
    ST_FETCH   = CORE_FETCH,
    ST_DECODE  = CORE_DECODE,
    ST_REQUEST = CORE_REQUEST,
    ST_WAIT    = CORE_WAIT,
    ST_EXECUTE = CORE_EXECUTE,
    ST_UPDATE  = CORE_UPDATE,
    ST_DONE    = CORE_DONE
  } core_state_e;

endpackage

// File: rtl/pc_select.sv
// Chooses the shared PC from the lowest-index enabled thread and flags
// whether any other enabled thread wants to go somewhere else.
module pc_select #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input  logic [THREADS-1:0]         thread_enable_i,
  input  logic [THREADS*PC_BITS-1:0] next_pc_i,
  output logic [PC_BITS-1:0]         sel_pc_o,
  output logic                       diverge_o
);

  // Priority pick of the lowest enabled lane; thread 0 when none is enabled.
  always_comb begin
    logic found;
    found    = 1'b0;
    sel_pc_o = next_pc_i[0 +: PC_BITS];
    for (int i = 0; i < THREADS; i++) begin
      if (!found && thread_enable_i[i]) begin
        sel_pc_o = next_pc_i[i*PC_BITS +: PC_BITS];
        found    = 1'b1;
      end
    end
  end

  // Any enabled lane disagreeing with the chosen PC is a divergence.
  always_comb begin
    diverge_o = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (thread_enable_i[i] && (next_pc_i[i*PC_BITS +: PC_BITS] != sel_pc_o)) begin
        diverge_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Per-core control FSM: walks a block through FETCH..UPDATE, owns the
// shared PC, waits on outstanding LSU traffic with a bounded timeout and
// records divergence. The state register is driven straight out on
// core_state so downstream units and checkers see the live phase.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS      = 4,
  parameter int PC_BITS      = DEFAULT_PC_BITS,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       fetch_ready,
  input  logic                       decoded_mem_req,
  input  logic                       decoded_ret,
  input  logic [THREADS-1:0]         thread_enable,
  input  logic [THREADS-1:0]         lsu_busy,
  input  logic [THREADS*PC_BITS-1:0] next_pc,
  output logic [2:0]                 core_state,
  output logic [PC_BITS-1:0]         current_pc,
  output logic                       done,
  output logic                       pc_divergence,
  output logic                       timeout
);

  // Last counter value before the WAIT budget is exhausted.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

  core_state_e        state_q;
  logic [7:0]         wait_cnt_q;
  logic [PC_BITS-1:0] pc_q;
  logic               done_q;
  logic               div_q;
  logic               timeout_q;

  logic [PC_BITS-1:0] sel_pc;
  logic               diverge;
  logic               wait_clear;

  pc_select #(
    .THREADS (THREADS),
    .PC_BITS (PC_BITS)
  ) u_pc_select (
    .thread_enable_i (thread_enable),
    .next_pc_i       (next_pc),
    .sel_pc_o        (sel_pc),
    .diverge_o       (diverge)
  );

  // WAIT may leave when nothing is outstanding on an enabled lane.
  assign wait_clear = !decoded_mem_req || ((lsu_busy & thread_enable) == '0);

  // Phase sequencing, PC ownership, wait counter and sticky status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      pc_q       <= '0;
      done_q     <= 1'b0;
      div_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            done_q    <= 1'b0;
            div_q     <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (fetch_ready) state_q <= ST_DECODE;
        end
        ST_DECODE:  state_q <= ST_REQUEST;
        ST_REQUEST: begin
          state_q    <= ST_WAIT;
          wait_cnt_q <= '0;
        end
        ST_WAIT: begin
          if (wait_clear) begin
            state_q <= ST_EXECUTE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q   <= ST_DONE;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ST_EXECUTE: state_q <= ST_UPDATE;
        ST_UPDATE: begin
          if (decoded_ret) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
            pc_q    <= sel_pc;
            if (diverge) div_q <= 1'b1;
          end
        end
        ST_DONE: done_q <= 1'b1;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_state    = state_q;
  assign current_pc    = pc_q;
  assign done          = done_q;
  assign pc_divergence = div_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: directed scenarios plus randomized instruction
// streams checked against a per-instruction phase/PC model.
module tb_core_scheduler;
  import gpu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        decoded_mem_req = 1'b0;
  logic        decoded_ret = 1'b0;
  logic [3:0]  thread_enable = 4'h0;
  logic [3:0]  lsu_busy = 4'h0;
  logic [31:0] next_pc = 32'h0;

  logic [2:0] core_state, to_state;
  logic [7:0] current_pc, to_pc;
  logic       done, pc_divergence, timeout;
  logic       to_done, to_div, to_timeout;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0] exp_pc;
  logic       exp_div, exp_done, exp_to;

  core_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .fetch_ready(fetch_ready),
    .decoded_mem_req(decoded_mem_req), .decoded_ret(decoded_ret),
    .thread_enable(thread_enable), .lsu_busy(lsu_busy), .next_pc(next_pc),
    .core_state(core_state), .current_pc(current_pc), .done(done),
    .pc_divergence(pc_divergence), .timeout(timeout)
  );

  core_scheduler #(.WAIT_TIMEOUT(TO)) dut_to (
    .clk(clk), .reset(reset), .start(start), .fetch_ready(fetch_ready),
    .decoded_mem_req(decoded_mem_req), .decoded_ret(decoded_ret),
    .thread_enable(thread_enable), .lsu_busy(lsu_busy), .next_pc(next_pc),
    .core_state(to_state), .current_pc(to_pc), .done(to_done),
    .pc_divergence(to_div), .timeout(to_timeout)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    exp_pc = 8'h00; exp_div = 1'b0; exp_done = 1'b0; exp_to = 1'b0;
  endtask

  task automatic start_block();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pc = 8'h00; exp_div = 1'b0; exp_done = 1'b0; exp_to = 1'b0;
    checks++;
    if (core_state !== CORE_FETCH) begin
      errors++; $display("FAIL start_state: got %0h expected %0h", core_state, CORE_FETCH);
    end
    checks++;
    if ({current_pc, done, pc_divergence, timeout} !== {8'h00, 3'b000}) begin
      errors++; $display("FAIL start_outputs: got pc=%0h d=%0b v=%0b t=%0b expected pc=0 d=0 v=0 t=0",
                         current_pc, done, pc_divergence, timeout);
    end
  endtask

  // One instruction from FETCH onwards, compared cycle by cycle.
  task automatic run_instr(input string tag, input int fdelay, input bit mem, input int busy_n,
                           input logic [3:0] en, input logic [3:0] bmask,
                           input logic [31:0] pcs, input bit ret);
    logic [2:0] exp_q[$];
    logic [7:0] chosen, pc_before;
    bit         found, stall;
    int         w, fi, wi;
    exp_q = {};
    for (int i = 0; i <= fdelay; i++) exp_q.push_back(CORE_FETCH);
    exp_q.push_back(CORE_DECODE);
    exp_q.push_back(CORE_REQUEST);
    stall = mem && ((bmask & en) != 4'h0) && (busy_n > 0);
    w = stall ? busy_n + 1 : 1;
    for (int i = 0; i < w; i++) exp_q.push_back(CORE_WAIT);
    exp_q.push_back(CORE_EXECUTE);
    exp_q.push_back(CORE_UPDATE);
    exp_q.push_back(ret ? CORE_DONE : CORE_FETCH);

    chosen = pcs[7:0];
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && !found) begin chosen = pcs[i*8 +: 8]; found = 1'b1; end
    end
    pc_before = exp_pc;
    if (ret) begin
      exp_done = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) if (en[i] && pcs[i*8 +: 8] != chosen) exp_div = 1'b1;
      exp_pc = chosen;
    end

    decoded_mem_req = mem;
    decoded_ret     = ret;
    thread_enable   = en;
    next_pc         = pcs;
    fi = 0; wi = 0;
    for (int k = 0; k < exp_q.size() - 1; k++) begin
      fetch_ready = 1'b1;
      lsu_busy    = 4'h0;
      if (exp_q[k] == CORE_FETCH) begin
        fetch_ready = (fi >= fdelay);
        fi++;
      end else if (exp_q[k] == CORE_WAIT) begin
        lsu_busy = (wi < busy_n) ? bmask : 4'h0;
        wi++;
      end
      tick();
      checks++;
      if (core_state !== exp_q[k+1]) begin
        errors++; $display("FAIL %s state[%0d]: got %0h expected %0h", tag, k + 1, core_state, exp_q[k+1]);
      end
      checks++;
      if (current_pc !== ((k + 1 == exp_q.size() - 1) ? exp_pc : pc_before)) begin
        errors++; $display("FAIL %s pc[%0d]: got %0h expected %0h", tag, k + 1, current_pc,
                           (k + 1 == exp_q.size() - 1) ? exp_pc : pc_before);
      end
    end
    lsu_busy = 4'h0;
    checks++;
    if ({done, pc_divergence, timeout} !== {exp_done, exp_div, exp_to}) begin
      errors++; $display("FAIL %s flags: got d=%0b v=%0b t=%0b expected d=%0b v=%0b t=%0b", tag,
                         done, pc_divergence, timeout, exp_done, exp_div, exp_to);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({core_state, current_pc, done, pc_divergence, timeout} !== 14'h0) begin
      errors++; $display("FAIL reset_values: got st=%0h pc=%0h d=%0b v=%0b t=%0b expected all 0",
                         core_state, current_pc, done, pc_divergence, timeout);
    end
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (core_state !== CORE_IDLE) begin
      errors++; $display("FAIL idle_hold: got %0h expected %0h", core_state, CORE_IDLE);
    end
    exp_pc = 8'h00; exp_div = 1'b0; exp_done = 1'b0; exp_to = 1'b0;
  endtask

  task automatic test_basic_alu();
    start_block();
    run_instr("basic_alu", 0, 0, 0, 4'b1111, 4'h0, {4{8'h01}}, 0);
  endtask

  task automatic test_mem_wait();
    run_instr("mem_wait", 0, 1, 5, 4'b1111, 4'b0101, {4{8'h02}}, 0);
  endtask

  task automatic test_masked_busy();
    run_instr("masked_busy", 1, 1, 6, 4'b0011, 4'b1100, {4{8'h03}}, 0);
  endtask

  task automatic test_divergence();
    run_instr("diverge", 0, 0, 0, 4'b1110, 4'h0, {8'h09, 8'h07, 8'h07, 8'h05}, 0);
    run_instr("div_sticky", 2, 0, 0, 4'b1111, 4'h0, {4{8'hFF}}, 0);
  endtask

  task automatic test_random();
    logic [31:0] pcs;
    do_reset();
    start_block();
    for (int n = 0; n < 25; n++) begin
      pcs = $urandom;
      if ($urandom_range(0, 3) == 0) pcs[$urandom_range(0, 3)*8 +: 8] = 8'hFF;
      run_instr("random", $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 6),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), pcs, 0);
    end
  endtask

  task automatic test_ret();
    run_instr("ret", 0, 0, 0, 4'b1111, 4'h0, {4{8'h5A}}, 1);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    checks++;
    if ({core_state, done} !== {CORE_DONE, 1'b1}) begin
      errors++; $display("FAIL done_hold: got st=%0h d=%0b expected st=7 d=1", core_state, done);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] exp_q[$];
    do_reset();
    start_block();
    fetch_ready = 1'b1; decoded_mem_req = 1'b1; decoded_ret = 1'b0;
    thread_enable = 4'hF; lsu_busy = 4'b0001; next_pc = 32'h0;
    exp_q = {CORE_DECODE, CORE_REQUEST};
    for (int i = 0; i < TO; i++) exp_q.push_back(CORE_WAIT);
    exp_q.push_back(CORE_DONE);
    foreach (exp_q[k]) begin
      tick();
      checks++;
      if (to_state !== exp_q[k]) begin
        errors++; $display("FAIL timeout_state[%0d]: got %0h expected %0h", k, to_state, exp_q[k]);
      end
      if (exp_q[k] != CORE_DONE) begin
        checks++;
        if (to_timeout !== 1'b0) begin
          errors++; $display("FAIL timeout_early[%0d]: got %0b expected 0", k, to_timeout);
        end
      end
    end
    checks++;
    if ({to_timeout, to_done} !== 2'b11) begin
      errors++; $display("FAIL timeout_flags: got t=%0b d=%0b expected t=1 d=1", to_timeout, to_done);
    end
    checks++;
    if ({core_state, timeout} !== {CORE_WAIT, 1'b0}) begin
      errors++; $display("FAIL long_wait: got st=%0h t=%0b expected st=4 t=0", core_state, timeout);
    end
    lsu_busy = 4'h0;
  endtask

  task automatic test_async_reset();
    do_reset();
    start_block();
    run_instr("pre_reset", 0, 0, 0, 4'b0011, {8'h00, 8'h00, 8'h44, 8'h33}, 32'h0000_4433, 0);
    fetch_ready = 1'b1; decoded_mem_req = 1'b1; thread_enable = 4'hF; lsu_busy = 4'hF;
    repeat (5) tick();
    checks++;
    if ({core_state, current_pc} !== {CORE_WAIT, 8'h33}) begin
      errors++; $display("FAIL pre_async: got st=%0h pc=%0h expected st=4 pc=33", core_state, current_pc);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({core_state, current_pc, done, pc_divergence, timeout} !== 14'h0) begin
      errors++; $display("FAIL async_reset: got st=%0h pc=%0h d=%0b v=%0b t=%0b expected all 0",
                         core_state, current_pc, done, pc_divergence, timeout);
    end
    tick();
    reset = 1'b1;
    lsu_busy = 4'h0;
    tick();
    checks++;
    if (core_state !== CORE_IDLE) begin
      errors++; $display("FAIL post_reset_idle: got %0h expected %0h", core_state, CORE_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_basic_alu();
    test_mem_wait();
    test_masked_busy();
    test_divergence();
    test_ret();
    test_random();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
- Per-core control FSM for the miniGPU. It steps all threads of a block through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE.
- It drives the `core_state` bus consumed by RegisterFile, the ALUs, the LSUs and the fetcher. RegisterFile reads operands in REQUEST (3'b011) and writes back in UPDATE (3'b110).
- It owns the shared program counter, waits for outstanding memory operations, and flags divergence and LSU hangs.

Parameters:
- THREADS, 4, threads per core (1..8).
- PC_BITS, 8, program counter width.
- WAIT_TIMEOUT, 255, maximum cycles spent in WAIT before abort (1..255).

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  launch block; sampled in IDLE only.
- fetch_ready  input  1  fetcher holds a valid instruction.
- decoded_mem_req  input  1  current instruction is LDR or STR.
- decoded_ret  input  1  current instruction is RET.
- thread_enable  input  THREADS  active thread mask for this block.
- lsu_busy  input  THREADS  per-thread LSU request outstanding.
- next_pc  input  THREADS*PC_BITS  per-thread PC from the PC/NZP units; thread i occupies bits [i*PC_BITS +: PC_BITS].
- core_state  output  3  IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- current_pc  output  PC_BITS  shared instruction address.
- done  output  1  block finished or aborted.
- pc_divergence  output  1  sticky; enabled threads disagreed on next_pc.
- timeout  output  1  sticky; WAIT exceeded WAIT_TIMEOUT.

Behaviour:
- Reset (reset=0, asynchronous, takes effect mid-operation):
  - core_state=IDLE, current_pc=0, done=0, pc_divergence=0, timeout=0, wait counter=0.
- All state updates occur on the rising edge of clk. Every output is registered.
- IDLE:
  - start=1 -> FETCH; current_pc=0; clear done, pc_divergence, timeout.
  - start=0 -> stay.
- FETCH: stay until fetch_ready=1, then -> DECODE. No timeout applies here.
- DECODE: exactly 1 cycle -> REQUEST.
- REQUEST: exactly 1 cycle -> WAIT.
- WAIT:
  - Minimum 1 cycle; the wait counter is cleared on entry.
  - Exit -> EXECUTE when decoded_mem_req=0, or when (lsu_busy & thread_enable)==0.
  - Busy bits of disabled threads are ignored.
  - Otherwise the counter increments each cycle. When it reaches WAIT_TIMEOUT: set timeout=1, done=1, -> DONE.
- EXECUTE: exactly 1 cycle -> UPDATE.
- UPDATE:
  - decoded_ret=1 -> DONE, done=1; current_pc unchanged.
  - Otherwise current_pc takes next_pc of the lowest-index enabled thread, then -> FETCH.
  - If thread_enable=0, current_pc takes thread 0's next_pc.
  - If any enabled thread's next_pc differs from the chosen one, set pc_divergence=1. Execution continues with the chosen PC.
- DONE: hold state; done=1. start is ignored. Only reset leaves DONE.
- PC arithmetic is a direct load, so no overflow handling is needed. A next_pc of 2^PC_BITS-1 is legal.
- Minimum non-memory instruction: 6 cycles (FETCH with fetch_ready already high, DECODE, REQUEST, WAIT, EXECUTE, UPDATE).
- start high in any state other than IDLE has no effect.

Decomposition:
- Package `gpu_pkg`: core_state encodings (CORE_IDLE..CORE_DONE as 3-bit localparams) and PC_BITS default. RegisterFile, ALU, LSU and PC units share these, so they must not be redefined locally.
- One natural sub-module, `pc_select`:
  - Combinational.
  - Picks the lowest-index enabled thread's next_pc.
  - Computes a divergence bit.
- The FSM and counters stay in core_scheduler.

Test Plan:
- Basic ALU instruction: reset, start=1, fetch_ready=1, decoded_mem_req=0, decoded_ret=0, thread_enable=4'b1111, all next_pc=8'h01 -> core_state sequence 001,010,011,100,101,110,001; current_pc=8'h01 after UPDATE.
- Memory wait: decoded_mem_req=1, lsu_busy=4'b0101 for 5 cycles then 0 -> WAIT held exactly 5 extra cycles, then EXECUTE; timeout=0.
- Masked busy: thread_enable=4'b0011, lsu_busy=4'b1100 held -> WAIT lasts 1 cycle only.
- Divergence: thread_enable=4'b1110, next_pc={8'h09,8'h07,8'h07,8'h05} -> current_pc=8'h07, pc_divergence=1 and stays 1 through later instructions.
- Timeout and RET:
  - WAIT_TIMEOUT=4, lsu_busy stuck at 4'b0001 -> timeout=1, done=1, core_state=111.
  - Separately, decoded_ret=1 in UPDATE -> DONE with current_pc unchanged.
- Async reset mid-WAIT: drop reset between clock edges -> all outputs return to reset values immediately, without a clock edge.
